eth_tx_framer: RTL
==================

Name: eth_tx_framer

Overview:
- Store-and-forward Ethernet transmit stage, directly downstream of the UDP packet former.
- Grants the former's UdpReq and captures one complete byte-stream frame (dst MAC through user payload) into an internal buffer.
- Replays the frame to a GMII-style byte interface with preamble/SFD, zero padding to 60 bytes, IEEE 802.3 FCS and inter-frame gap.
- One frame in flight; the former holds further frames in its own RAM until the next grant.

Parameters:
- BUF_AW, 11, buffer address width; capacity 2**BUF_AW bytes.
- MAX_LEN, 1514, largest accepted frame length in bytes, excluding FCS.
- MIN_LEN, 60, minimum length before FCS; shorter frames are padded with 0x00.
- IFG_LEN, 12, idle byte-times after the last FCS byte.

Ports:
- Clk  in  1  single clock for all logic.
- nRst  in  1  reset; synchronous, active-low.
- UdpReq  in  1  upstream has a frame pending.
- ReqConfirm  out  1  grant to upstream; high throughout the RX state.
- ValIn  in  1  DataIn/SoFIn/EoFIn qualifier.
- SoFIn  in  1  first byte of frame, with ValIn.
- EoFIn  in  1  last byte of frame, with ValIn.
- DataIn  in  8  frame byte.
- TxCe  in  1  transmit byte strobe; every TX-side step advances only when TxCe=1.
- TxEn  out  1  GMII transmit enable.
- TxD  out  8  GMII transmit data.
- FrameCnt  out  16  frames transmitted; wraps.
- DropCnt  out  16  frames dropped because they exceeded MAX_LEN; wraps.

Behaviour:
- Reset (nRst=0 at a Clk edge):
  - Outputs ReqConfirm=0, TxEn=0, TxD=0, FrameCnt=0, DropCnt=0.
  - State IDLE, write pointer and length cleared.
  - Reset mid-frame abandons the frame with no partial output; TxEn drops on the next edge.
- States: IDLE, RX, PRE, DATA, PAD, FCS, IFG.
- IDLE:
  - If UdpReq=1, go to RX next cycle and set ReqConfirm=1.
- RX:
  - Bytes with ValIn=1 are ignored until one arrives with SoFIn=1. That byte is written to address 0 and Len=1.
  - Each following valid byte is written at Len, then Len+1.
  - A second SoFIn while collecting restarts at address 0; the earlier bytes are discarded and not counted as a drop.
  - A valid byte with EoFIn=1 is stored. ReqConfirm falls on the next edge and the state goes to PRE.
  - SoFIn and EoFIn together give a 1-byte frame.
  - If Len reaches MAX_LEN and another valid non-EoF byte arrives: DropCnt+1, then discard bytes until EoFIn. Go to IDLE, not PRE.
  - UdpReq falling during RX has no effect; the frame completes on EoFIn.
- TX steps; each step consumes exactly one TxCe=1 cycle, and TxEn/TxD are registered and updated only on TxCe cycles:
  - PRE: 7 bytes of 0x55, then 0xD5.
  - DATA: buffer bytes 0..Len-1. The read is issued one cycle ahead so there is no bubble at TxCe=1 every cycle.
  - PAD: 0x00 while byte count < MIN_LEN. Skipped if Len >= MIN_LEN.
  - FCS: 4 bytes.
  - IFG: TxEn=0, TxD=0 for IFG_LEN TxCe cycles. Then FrameCnt+1 and go to IDLE.
- TxEn is 1 from the first preamble byte through the last FCS byte.
- First preamble byte appears on the first TxCe=1 cycle at least 1 Clk after the EoF byte is captured.
- CRC:
  - CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF.
  - Updated over DATA and PAD bytes only, LSB-first byte processing.
  - FCS byte k = ~crc[8k+7:8k], k=0..3.
- Counters are 16-bit modulo.
- TxCe=0 freezes all TX state, TxEn and TxD. It has no effect on RX capture, which is qualified by ValIn only.
- A new grant is never issued before the IFG completes.

Test Plan:
- Single 100-byte frame, TxCe=1 constant:
  - TxD shows 55x7, D5, the 100 bytes, then 4 FCS bytes; 108+4 cycles of TxEn.
  - Golden CRC-32 model agrees, and the CRC over bytes+FCS leaves residue register 0xDEBB20E3.
  - FrameCnt=1.
- 42-byte frame: 18 bytes of 0x00 are inserted before the FCS; TxEn length = 8+60+4 = 72 TxCe cycles; FCS is computed over the padded 60 bytes.
- TxCe toggling every cycle (half rate), 64-byte frame: TxD changes only on TxCe cycles; the byte sequence is identical to the full-rate run; 12 idle TxCe cycles precede ReqConfirm re-asserting.
- 1515-byte frame: DropCnt=1, no TxEn activity, return to IDLE; the following 64-byte frame transmits correctly.
- SoFIn re-asserted after 10 bytes, then a 70-byte frame ending in EoFIn: only the 70 bytes are transmitted, DropCnt unchanged.
- nRst=0 during the DATA phase: TxEn=0 on the next edge, counters=0; the next frame with UdpReq transmits normally.

Source files
------------

// File: rtl/eth_tx_framer_if.sv
// Upstream handshake and byte bus between the UDP packet former and the
// Ethernet transmit framer.
//   UdpReq      former -> framer  frame pending
//   ReqConfirm  framer -> former  grant, high while the framer collects a frame
//   ValIn       former -> framer  qualifies DataIn/SoFIn/EoFIn
//   SoFIn       former -> framer  first byte of frame
//   EoFIn       former -> framer  last byte of frame
//   DataIn      former -> framer  frame byte
interface eth_tx_framer_if;
  logic       UdpReq;
  logic       ReqConfirm;
  logic       ValIn;
  logic       SoFIn;
  logic       EoFIn;
  logic [7:0] DataIn;

  modport master (
    output UdpReq, ValIn, SoFIn, EoFIn, DataIn,
    input  ReqConfirm
  );

  modport slave (
    input  UdpReq, ValIn, SoFIn, EoFIn, DataIn,
    output ReqConfirm
  );
endinterface

// File: rtl/eth_tx_framer.sv
// Store-and-forward Ethernet transmit framer. Grants the UDP former, captures
// one whole frame (dst MAC .. payload) into a byte buffer, then replays it on
// a GMII-style byte interface with preamble/SFD, zero padding to MIN_LEN,
// CRC-32 FCS and an inter-frame gap.
// Ports:
//   Clk, nRst         clock; synchronous active-low reset
//   up (slave)        UdpReq/ReqConfirm grant and ValIn/SoFIn/EoFIn/DataIn bytes
//   TxCe              transmit byte strobe; all TX progress gated by it
//   TxEn, TxD         GMII transmit enable and data (registered)
//   FrameCnt, DropCnt frames sent / frames dropped for exceeding MAX_LEN
module eth_tx_framer #(
  parameter int unsigned BUF_AW  = 11,
  parameter int unsigned MAX_LEN = 1514,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned IFG_LEN = 12
) (
  input  logic              Clk,
  input  logic              nRst,
  eth_tx_framer_if.slave    up,
  input  logic              TxCe,
  output logic              TxEn,
  output logic [7:0]        TxD,
  output logic [15:0]       FrameCnt,
  output logic [15:0]       DropCnt
);

  localparam int unsigned LEN_W    = BUF_AW + 1;
  localparam int unsigned BUF_SIZE = 2 ** BUF_AW;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_PRE, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   tx_cnt;
  logic               collecting;
  logic               dropping;
  logic [31:0]        crc;

  logic [7:0]         mem [BUF_SIZE];
  logic [7:0]         rd_data;

  logic               rx_byte_c;
  logic               at_max_c;
  logic               wr_en_c;
  logic [BUF_AW-1:0]  wr_addr_c;
  logic [BUF_AW-1:0]  rd_addr_c;

  // Reflected CRC-32 update over one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Buffer write decode and read-ahead address: in DATA the address of the
  // byte needed on the next TxCe is presented one clock early.
  always_comb begin
    rx_byte_c = (state == S_RX) && up.ValIn && !dropping;
    at_max_c  = (len == LEN_W'(MAX_LEN));
    wr_en_c   = rx_byte_c && (up.SoFIn || (collecting && !at_max_c));
    wr_addr_c = up.SoFIn ? '0 : len[BUF_AW-1:0];
    rd_addr_c = '0;
    if (state == S_DATA) begin
      rd_addr_c = TxCe ? BUF_AW'(tx_cnt + LEN_W'(1)) : tx_cnt[BUF_AW-1:0];
    end
  end

  // Frame buffer: one write port from RX, one registered read port for TX.
  always_ff @(posedge Clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= up.DataIn;
    end
    rd_data <= mem[rd_addr_c];
  end

  // Control FSM with registered outputs.
  always_ff @(posedge Clk) begin
    if (!nRst) begin
      state         <= S_IDLE;
      up.ReqConfirm <= 1'b0;
      TxEn          <= 1'b0;
      TxD           <= 8'h00;
      FrameCnt      <= 16'h0000;
      DropCnt       <= 16'h0000;
      len           <= '0;
      tx_cnt        <= '0;
      collecting    <= 1'b0;
      dropping      <= 1'b0;
      crc           <= '1;
    end else begin
      case (state)
        S_IDLE: begin
          if (up.UdpReq) begin
            state         <= S_RX;
            up.ReqConfirm <= 1'b1;
            len           <= '0;
            collecting    <= 1'b0;
            dropping      <= 1'b0;
            tx_cnt        <= '0;
            crc           <= '1;
          end
        end

        S_RX: begin
          if (up.ValIn) begin
            if (dropping) begin
              // Oversized frame: swallow bytes until its end, then re-grant.
              if (up.EoFIn) begin
                state         <= S_IDLE;
                up.ReqConfirm <= 1'b0;
                dropping      <= 1'b0;
              end
            end else if (up.SoFIn) begin
              // SoF always restarts at address 0, discarding any partial frame.
              len        <= LEN_W'(1);
              collecting <= 1'b1;
              if (up.EoFIn) begin
                state         <= S_PRE;
                up.ReqConfirm <= 1'b0;
              end
            end else if (collecting) begin
              if (at_max_c) begin
                DropCnt    <= DropCnt + 16'd1;
                collecting <= 1'b0;
                if (up.EoFIn) begin
                  state         <= S_IDLE;
                  up.ReqConfirm <= 1'b0;
                end else begin
                  dropping <= 1'b1;
                end
              end else begin
                len <= len + LEN_W'(1);
                if (up.EoFIn) begin
                  state         <= S_PRE;
                  up.ReqConfirm <= 1'b0;
                end
              end
            end
          end
        end

        S_PRE: begin
          if (TxCe) begin
            TxEn <= 1'b1;
            if (tx_cnt == LEN_W'(7)) begin
              TxD    <= 8'hD5;
              state  <= S_DATA;
              tx_cnt <= '0;
            end else begin
              TxD    <= 8'h55;
              tx_cnt <= tx_cnt + LEN_W'(1);
            end
          end
        end

        S_DATA: begin
          if (TxCe) begin
            TxD <= rd_data;
            crc <= crc_byte(crc, rd_data);
            if (tx_cnt == len - LEN_W'(1)) begin
              // Pad continues the byte count from len up to MIN_LEN.
              if (len < LEN_W'(MIN_LEN)) begin
                state  <= S_PAD;
                tx_cnt <= len;
              end else begin
                state  <= S_FCS;
                tx_cnt <= '0;
              end
            end else begin
              tx_cnt <= tx_cnt + LEN_W'(1);
            end
          end
        end

        S_PAD: begin
          if (TxCe) begin
            TxD <= 8'h00;
            crc <= crc_byte(crc, 8'h00);
            if (tx_cnt == LEN_W'(MIN_LEN - 1)) begin
              state  <= S_FCS;
              tx_cnt <= '0;
            end else begin
              tx_cnt <= tx_cnt + LEN_W'(1);
            end
          end
        end

        S_FCS: begin
          // Shift the CRC down so the next FCS byte is always crc[7:0].
          if (TxCe) begin
            TxD <= ~crc[7:0];
            crc <= {8'h00, crc[31:8]};
            if (tx_cnt == LEN_W'(3)) begin
              state  <= S_IFG;
              tx_cnt <= '0;
            end else begin
              tx_cnt <= tx_cnt + LEN_W'(1);
            end
          end
        end

        S_IFG: begin
          if (TxCe) begin
            TxEn <= 1'b0;
            TxD  <= 8'h00;
            if (tx_cnt == LEN_W'(IFG_LEN - 1)) begin
              state    <= S_IDLE;
              FrameCnt <= FrameCnt + 16'd1;
              tx_cnt   <= '0;
            end else begin
              tx_cnt <= tx_cnt + LEN_W'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
